// File: rtl/fifo_disp_pkg.sv
// Shared constants for the FIFO drain display: active-low 7-segment patterns
// (bit 6 = segment a) and FSM state encodings.
package fifo_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SHOW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    LATCH = ST_LATCH,
    SHOW  = ST_SHOW
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (bit 6 = segment a).
module seg7_decode
  import fifo_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fifo_drain_display.sv
// Pops nibbles from a synchronous FIFO and holds each on a 7-segment digit for
// a programmable dwell; the last value stays up while the FIFO is empty.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO
// READ  | pop request on the FIFO read port
// LATCH | FIFO data valid; capture, display, start dwell
// SHOW  | hold the digit until the dwell counter reaches zero
module fifo_drain_display
  import fifo_disp_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int CNT_W        = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             fifo_read,
  output logic [6:0]       seg_out,
  output logic             digit_valid,
  output logic [7:0]       shown_count
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] dwell;
  logic [WIDTH-1:0] nibble;
  logic [WIDTH-1:0] dec_in;
  logic [6:0]       seg_next;

  // In LATCH the nibble register is being loaded, so decode the FIFO word directly.
  assign dec_in = (state == LATCH) ? fifo_out : nibble;

  seg7_decode u_decode (
    .nibble (dec_in[3:0]),
    .seg    (seg_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      dwell       <= '0;
      nibble      <= '0;
      fifo_read   <= 1'b0;
      seg_out     <= SEG_BLANK;
      digit_valid <= 1'b0;
      shown_count <= 8'd0;
    end else begin
      fifo_read <= 1'b0;
      case (state)
        IDLE: begin
          // The read strobe is registered alongside the move to READ, using the
          // same non-empty sample, so it is high for exactly the READ cycle.
          if (enable && !fifo_empty) begin
            state     <= READ;
            fifo_read <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          nibble      <= fifo_out;
          seg_out     <= seg_next;
          digit_valid <= 1'b1;
          shown_count <= shown_count + 8'd1;
          dwell       <= DWELL_LOAD;
          state       <= SHOW;
        end
        SHOW: begin
          seg_out <= seg_next;
          if (dwell == '0) state <= IDLE;
          else             dwell <= dwell - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
